// File: rtl/sha256_pkg.sv
// ----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message-schedule controller:
//   - state_t    : FSM state encoding (IDLE / EMIT / DONE)
//   - WORD_W     : width of one schedule word
//   - WIN_LEN    : depth of the sliding W window (16 words)
//   - ROUNDS_DEF : default number of schedule words emitted per block
//   - s0 / s1    : the small sigma functions of the W expansion
// ----------------------------------------------------------------------------
package sha256_pkg;

   localparam int WORD_W     = 32;
   localparam int WIN_LEN    = 16;
   localparam int ROUNDS_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
   function automatic logic [WORD_W-1:0] s0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   // sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
   function automatic logic [WORD_W-1:0] s1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

endpackage : sha256_pkg

// File: rtl/sha256_w_expand.sv
// ----------------------------------------------------------------------------
// sha256_w_expand
// Purely combinational W expansion:
//   o_w_next = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]   (mod 2^32)
// Seen from the 16-deep window, those taps are win[14], win[9], win[1], win[0].
// Ports:
//   i_w0, i_w1, i_w9, i_w14 : window taps
//   o_w_next                : next schedule word (enters at win[15])
// ----------------------------------------------------------------------------
module sha256_w_expand
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] i_w0,
   input  logic [WORD_W-1:0] i_w1,
   input  logic [WORD_W-1:0] i_w9,
   input  logic [WORD_W-1:0] i_w14,
   output logic [WORD_W-1:0] o_w_next
);

   // Carries out of bit 31 drop naturally, giving the mod 2^32 sum.
   assign o_w_next = s1(i_w14) + i_w9 + s0(i_w1) + i_w0;

endmodule : sha256_w_expand

// File: rtl/sha256_w_sched_ctrl.sv
// ----------------------------------------------------------------------------
// sha256_w_sched_ctrl
// Accepts one 512-bit message block and streams the SHA-256 message schedule
// W0..W(ROUNDS-1), one word per handshake, from a 16-word sliding window.
// Ports:
//   CLK, RST          : clock, asynchronous active-low reset
//   in_valid/in_ready : block handshake; block_in = {W0, ..., W15}, big-endian
//   w_valid/w_ready   : word handshake; w_out = W_t, w_round = t
//   abort             : synchronous cancel of the block in flight
//   busy              : FSM not in IDLE
//   done              : one-cycle pulse after the last word is taken
// w_out is driven straight from the window register, so nothing on the input
// side reaches it combinationally.
// ----------------------------------------------------------------------------
module sha256_w_sched_ctrl
   import sha256_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEF
)(
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIN_LEN*WORD_W-1:0] block_in,
   output logic                   w_valid,
   input  logic                   w_ready,
   output logic [WORD_W-1:0]      w_out,
   output logic [5:0]             w_round,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done
);

   localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [5:0]          r_t;
   logic [WORD_W-1:0]   r_win [WIN_LEN];
   logic [WORD_W-1:0]   w_w_next;
   logic                w_accept;
   logic                w_shift;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and FSM outputs
   // -------------------------------------------------------------------------
   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_shift     = 1'b0;
      in_ready    = 1'b0;
      w_valid     = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // abort is meaningless here, so it is not looked at.
            // in_ready is gated by RST so it stays low while reset is held.
            in_ready = RST;
            busy     = 1'b0;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_EMIT;
            end
         end
         ST_EMIT: begin
            w_valid = 1'b1;
            if (abort) begin
               // abort beats a simultaneous handshake: no shift, no t++.
               w_state_nxt = ST_IDLE;
            end else if (w_ready) begin
               w_shift = 1'b1;
               if (r_t == T_LAST) begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // abort also lands in IDLE, and it suppresses the pulse.
            done        = ~abort;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Window and round counter
   // -------------------------------------------------------------------------
   sha256_w_expand u_expand (
      .i_w0     (r_win[0]),
      .i_w1     (r_win[1]),
      .i_w9     (r_win[9]),
      .i_w14    (r_win[14]),
      .o_w_next (w_w_next)
   );

   // NOTE: the window is an array of flops, not a RAM, so it can and does take
   // the async reset; that is what makes w_out read 0 while RST is low.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_t <= '0;
         for (int k = 0; k < WIN_LEN; k++) begin
            r_win[k] <= '0;
         end
      end else if (w_accept) begin
         r_t <= '0;
         for (int k = 0; k < WIN_LEN; k++) begin
            r_win[k] <= block_in[WORD_W*(WIN_LEN-k)-1 -: WORD_W];
         end
      end else if (w_shift) begin
         r_t <= r_t + 6'd1;
         for (int k = 0; k < WIN_LEN-1; k++) begin
            r_win[k] <= r_win[k+1];
         end
         r_win[WIN_LEN-1] <= w_w_next;
      end
   end

   assign w_out   = r_win[0];
   assign w_round = r_t;

endmodule : sha256_w_sched_ctrl
